axi4l_ipif_mc: RTL

//  AXI4-Lite slave that bridges one AXI port to C_NUM_CH independent req/ack register interfaces (IPIF).

---
 rtl/axi4l_ipif_mc_if.sv | 41 ++++
 rtl/axi4l_ipif_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_ipif_mc_if.sv
// AXI4-Lite slave-side bus bundle for the multi-channel IPIF bridge.
// The master modport is the interconnect/bench side, the slave modport is the bridge.
interface axi4l_ipif_mc_if #(
  parameter int C_DATA_WIDTH = 32
);
  logic [31:0]               awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [31:0]               araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4l_ipif_mc.sv
// AXI4-Lite slave bridging one AXI port to C_NUM_CH req/ack register channels.
// One transaction in flight; read/write round-robin; ack timeout -> SLVERR,
// out-of-range channel -> DECERR.
module axi4l_ipif_mc #(
  parameter int C_ADDR_WIDTH    = 12,
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_NUM_CH        = 4,
  parameter int C_CH_ADDR_WIDTH = 10,
  parameter int C_TIMEOUT       = 16
) (
  input  logic                             aclk,
  input  logic                             areset,
  axi4l_ipif_mc_if.slave                   s_axi,
  output logic [C_CH_ADDR_WIDTH-3:0]       wr_addr,
  output logic [C_NUM_CH-1:0]              wr_req,
  output logic [C_DATA_WIDTH/8-1:0]        wr_be,
  output logic [C_DATA_WIDTH-1:0]          wr_data,
  input  logic [C_NUM_CH-1:0]              wr_ack,
  output logic [C_CH_ADDR_WIDTH-3:0]       rd_addr,
  output logic [C_NUM_CH-1:0]              rd_req,
  input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] rd_data,
  input  logic [C_NUM_CH-1:0]              rd_ack
);

  localparam int IDX_W = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1;
  localparam int TMO_W = $clog2(C_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_TIMEOUT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_WAIT, RD_WAIT, WR_RESP, RD_RESP} state_t;

  state_t                      state;
  logic                        up;
  logic                        aw_full, w_full, ar_full;
  logic [C_CH_ADDR_WIDTH-3:0]  aw_word, ar_word;
  logic [IDX_W-1:0]            aw_idx, ar_idx;
  logic [C_DATA_WIDTH-1:0]     w_data;
  logic [C_DATA_WIDTH/8-1:0]   w_strb;
  logic                        prefer_wr;
  logic [IDX_W-1:0]            sel;
  logic [TMO_W-1:0]            tmo;
  logic                        bvalid_r, rvalid_r;
  logic [1:0]                  bresp_r, rresp_r;
  logic [C_DATA_WIDTH-1:0]     rdata_r;
  logic                        aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                        wr_elig, rd_elig;
  logic                        unused_bits;

  // With a single channel there are no index bits: every address maps to channel 0.
  function automatic logic [IDX_W-1:0] idx_sel(input logic [IDX_W-1:0] idx);
    return (C_NUM_CH == 1) ? '0 : idx;
  endfunction

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return (C_NUM_CH == 1) || (int'(idx) < C_NUM_CH);
  endfunction

  function automatic logic [C_NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [C_NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < C_NUM_CH; i++)
      if (int'(idx) == i) v[i] = 1'b1;
    return v;
  endfunction

  // up keeps every ready low while reset is asserted and for the reset edge itself.
  assign s_axi.awready = up & ~aw_full;
  assign s_axi.wready  = up & ~w_full;
  assign s_axi.arready = up & ~ar_full;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bresp   = bresp_r;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rresp   = rresp_r;
  assign s_axi.rdata   = rdata_r;

  assign aw_hs   = s_axi.awvalid & s_axi.awready;
  assign w_hs    = s_axi.wvalid & s_axi.wready;
  assign ar_hs   = s_axi.arvalid & s_axi.arready;
  assign b_hs    = bvalid_r & s_axi.bready;
  assign r_hs    = rvalid_r & s_axi.rready;
  assign wr_elig = aw_full & w_full;
  assign rd_elig = ar_full;

  // Protection bits and address bits outside the decode are deliberately ignored.
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

  // Holding-register occupancy: filled on address/data handshake, freed on response handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      up      <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
    end else begin
      up <= 1'b1;
      if (aw_hs)      aw_full <= 1'b1;
      else if (b_hs)  aw_full <= 1'b0;
      if (w_hs)       w_full  <= 1'b1;
      else if (b_hs)  w_full  <= 1'b0;
      if (ar_hs)      ar_full <= 1'b1;
      else if (r_hs)  ar_full <= 1'b0;
    end
  end

  // Holding-register payload; only meaningful while the matching full flag is set.
  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      aw_word <= s_axi.awaddr[C_CH_ADDR_WIDTH-1:2];
      aw_idx  <= s_axi.awaddr[C_CH_ADDR_WIDTH +: IDX_W];
    end
    if (w_hs) begin
      w_data <= s_axi.wdata;
      w_strb <= s_axi.wstrb;
    end
    if (ar_hs) begin
      ar_word <= s_axi.araddr[C_CH_ADDR_WIDTH-1:2];
      ar_idx  <= s_axi.araddr[C_CH_ADDR_WIDTH +: IDX_W];
    end
  end

  // Transaction FSM: arbitrate, pulse req, wait for ack or timeout, hold the response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      prefer_wr <= 1'b1;
      sel       <= '0;
      tmo       <= '0;
      wr_req    <= '0;
      rd_req    <= '0;
      wr_addr   <= '0;
      wr_be     <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      rvalid_r  <= 1'b0;
      rresp_r   <= 2'b00;
      rdata_r   <= '0;
    end else begin
      wr_req <= '0;
      rd_req <= '0;
      case (state)
        IDLE: begin
          tmo <= '0;
          if (wr_elig && (!rd_elig || prefer_wr)) begin
            prefer_wr <= 1'b0;
            sel       <= idx_sel(aw_idx);
            wr_addr   <= aw_word;
            wr_be     <= w_strb;
            wr_data   <= w_data;
            if (idx_ok(aw_idx)) begin
              wr_req <= onehot(idx_sel(aw_idx));
              state  <= WR_WAIT;
            end else begin
              bvalid_r <= 1'b1;
              bresp_r  <= RESP_DECERR;
              state    <= WR_RESP;
            end
          end else if (rd_elig) begin
            prefer_wr <= 1'b1;
            sel       <= idx_sel(ar_idx);
            rd_addr   <= ar_word;
            if (idx_ok(ar_idx)) begin
              rd_req <= onehot(idx_sel(ar_idx));
              state  <= RD_WAIT;
            end else begin
              rvalid_r <= 1'b1;
              rresp_r  <= RESP_DECERR;
              rdata_r  <= '0;
              state    <= RD_RESP;
            end
          end
        end
        // tmo==0 marks the req cycle itself, where ack is not yet sampled.
        WR_WAIT: begin
          if (tmo == '0) begin
            tmo <= TMO_W'(1);
          end else if (wr_ack[sel]) begin
            bvalid_r <= 1'b1;
            bresp_r  <= RESP_OKAY;
            state    <= WR_RESP;
          end else if (tmo == TMO_LAST) begin
            bvalid_r <= 1'b1;
            bresp_r  <= RESP_SLVERR;
            state    <= WR_RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RD_WAIT: begin
          if (tmo == '0) begin
            tmo <= TMO_W'(1);
          end else if (rd_ack[sel]) begin
            rvalid_r <= 1'b1;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= rd_data[sel*C_DATA_WIDTH +: C_DATA_WIDTH];
            state    <= RD_RESP;
          end else if (tmo == TMO_LAST) begin
            rvalid_r <= 1'b1;
            rresp_r  <= RESP_SLVERR;
            rdata_r  <= '0;
            state    <= RD_RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WR_RESP: begin
          if (s_axi.bready) begin
            bvalid_r <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_RESP: begin
          if (s_axi.rready) begin
            rvalid_r <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
